// File: rtl/lif_membrane_core.sv
// Leaky integrate-and-fire membrane stage: double-exponential synaptic current,
// leak/integrate, threshold spike and step-counted refractory hold.
module lif_membrane_core #(
    parameter int V_W        = 24,
    parameter int LEAK_SHIFT = 3,
    parameter int REF_STEPS  = 4,
    parameter int V_RESET    = 0,
    parameter int V_FLOOR    = -65536
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step_valid,
    output logic                  step_ready,
    input  logic [15:0]           ES_plus_reg,
    input  logic [15:0]           ES_minus_reg,
    input  logic [15:0]           IS_plus_reg,
    input  logic [15:0]           IS_minus_reg,
    input  logic signed [V_W-1:0] threshold,
    input  logic                  clr_count,
    output logic signed [V_W-1:0] v_mem,
    output logic                  spike,
    output logic                  refractory,
    output logic                  step_done,
    output logic [15:0]           spike_count
);

    typedef enum logic [1:0] {S_IDLE, S_SUM, S_UPDATE, S_DONE} state_t;

    localparam logic signed [V_W-1:0] V_RESET_V = V_W'(V_RESET);
    localparam logic signed [V_W+1:0] FLOOR_X   = (V_W+2)'(V_FLOOR);
    localparam logic signed [V_W+1:0] VMAX_X    = {3'b000, {(V_W-1){1'b1}}};
    localparam logic [7:0]            REF_V     = 8'(REF_STEPS);

    state_t                state_q;
    logic [15:0]           esp_q, esm_q, isp_q, ism_q;
    logic signed [V_W-1:0] thr_q;
    logic signed [V_W-1:0] v_q;
    logic signed [17:0]    isyn_q;
    logic [7:0]            ref_q;
    logic                  spike_q, refr_q, done_q;
    logic [15:0]           cnt_q;

    logic signed [16:0]    diff_e, diff_i;
    logic signed [17:0]    isyn_d;
    logic signed [V_W+1:0] v_ext, leak, v_sum, v_clamp, thr_ext;
    logic                  fire;

    always_comb begin
        diff_e  = $signed({1'b0, esm_q}) - $signed({1'b0, esp_q});
        diff_i  = $signed({1'b0, isp_q}) - $signed({1'b0, ism_q});
        isyn_d  = $signed({diff_e[16], diff_e}) - $signed({diff_i[16], diff_i});
        v_ext   = $signed({{2{v_q[V_W-1]}}, v_q});
        leak    = v_ext >>> LEAK_SHIFT;
        v_sum   = v_ext - leak + $signed({{(V_W-16){isyn_q[17]}}, isyn_q});
        v_clamp = v_sum;
        if (v_sum < FLOOR_X) begin
            v_clamp = FLOOR_X;
        end else if (v_sum > VMAX_X) begin
            v_clamp = VMAX_X;
        end
        thr_ext = $signed({{2{thr_q[V_W-1]}}, thr_q});
        fire    = (v_clamp >= thr_ext);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            esp_q   <= '0;
            esm_q   <= '0;
            isp_q   <= '0;
            ism_q   <= '0;
            thr_q   <= '0;
            v_q     <= V_RESET_V;
            isyn_q  <= '0;
            ref_q   <= '0;
            spike_q <= 1'b0;
            refr_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q  <= 1'b0;
            spike_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (step_valid) begin
                        esp_q   <= ES_plus_reg;
                        esm_q   <= ES_minus_reg;
                        isp_q   <= IS_plus_reg;
                        ism_q   <= IS_minus_reg;
                        thr_q   <= threshold;
                        state_q <= S_SUM;
                    end
                end
                S_SUM: begin
                    isyn_q  <= isyn_d;
                    state_q <= S_UPDATE;
                end
                S_UPDATE: begin
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                    // While refractory the current is discarded and the potential pinned.
                    if (ref_q != 8'd0) begin
                        v_q    <= V_RESET_V;
                        ref_q  <= ref_q - 8'd1;
                        refr_q <= (ref_q != 8'd1);
                    end else if (fire) begin
                        v_q     <= V_RESET_V;
                        spike_q <= 1'b1;
                        ref_q   <= REF_V;
                        refr_q  <= (REF_V != 8'd0);
                    end else begin
                        v_q <= v_clamp[V_W-1:0];
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (clr_count) begin
                cnt_q <= '0;
            end else if (state_q == S_UPDATE && ref_q == 8'd0 && fire && cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign step_ready  = (state_q == S_IDLE);
    assign v_mem       = v_q;
    assign spike       = spike_q;
    assign refractory  = refr_q;
    assign step_done   = done_q;
    assign spike_count = cnt_q;

endmodule

// File: tb/tb_lif_membrane_core.sv
// Directed and randomized checks of lif_membrane_core against an arithmetic
// reference model of the membrane equations.
module tb_lif_membrane_core;

    localparam int V_W = 24;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  step_valid = 1'b0;
    logic                  step_ready;
    logic [15:0]           ES_plus_reg = '0, ES_minus_reg = '0, IS_plus_reg = '0, IS_minus_reg = '0;
    logic signed [V_W-1:0] threshold = '0;
    logic                  clr_count = 1'b0;
    logic signed [V_W-1:0] v_mem;
    logic                  spike, refractory, step_done;
    logic [15:0]           spike_count;

    int vectors = 0;
    int miscompares = 0;
    int accepts = 0;
    int dones = 0;

    // reference model state
    int m_v = 0;
    int m_ref = 0;
    int m_cnt = 0;
    bit m_spk = 0;

    lif_membrane_core dut (
        .clk(clk), .reset(reset), .step_valid(step_valid), .step_ready(step_ready),
        .ES_plus_reg(ES_plus_reg), .ES_minus_reg(ES_minus_reg),
        .IS_plus_reg(IS_plus_reg), .IS_minus_reg(IS_minus_reg),
        .threshold(threshold), .clr_count(clr_count), .v_mem(v_mem), .spike(spike),
        .refractory(refractory), .step_done(step_done), .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!reset && step_valid && step_ready) accepts <= accepts + 1;
    always @(negedge clk) if (step_done) dones <= dones + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    function automatic int floor_div8(input int x);
        if (x >= 0) return x / 8;
        return -((-x + 7) / 8);
    endfunction

    function automatic void model_step(input int esp, input int esm, input int isp,
                                       input int ism, input int thr, input bit clr);
        int isyn, nv;
        isyn  = (esm - esp) - (isp - ism);
        m_spk = 0;
        if (m_ref > 0) begin
            m_v = 0;
            m_ref--;
        end else begin
            nv = m_v - floor_div8(m_v) + isyn;
            if (nv < -65536) nv = -65536;
            if (nv > 8388607) nv = 8388607;
            if (nv >= thr) begin
                m_spk = 1;
                m_v   = 0;
                m_ref = 4;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                m_v = nv;
            end
        end
        if (clr) m_cnt = 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_v = 0; m_ref = 0; m_cnt = 0;
    endtask

    task automatic do_step(input int esp, input int esm, input int isp, input int ism,
                           input int thr, input bit glitch, input bit clr);
        int d0, a0;
        @(negedge clk);
        chk("ready_idle", step_ready, 1);
        ES_plus_reg  = esp[15:0];
        ES_minus_reg = esm[15:0];
        IS_plus_reg  = isp[15:0];
        IS_minus_reg = ism[15:0];
        threshold    = thr[V_W-1:0];
        clr_count    = clr;
        step_valid   = 1'b1;
        d0 = dones;
        a0 = accepts;
        @(posedge clk); #1;
        step_valid   = 1'b0;
        ES_plus_reg  = 16'($urandom);
        ES_minus_reg = 16'($urandom);
        IS_plus_reg  = 16'($urandom);
        IS_minus_reg = 16'($urandom);
        threshold    = V_W'($urandom);
        @(negedge clk);
        step_valid = glitch;
        @(posedge clk); #1;
        step_valid = 1'b0;
        chk("done_early", step_done, 0);
        model_step(esp, esm, isp, ism, thr, clr);
        @(posedge clk); #1;
        chk("step_done", step_done, 1);
        chk("spike", spike, 32'(m_spk));
        chk("v_mem", $signed(v_mem), m_v);
        chk("refractory", refractory, 32'(m_ref != 0));
        chk("spike_count", spike_count, m_cnt);
        @(posedge clk); #1;
        chk("done_clear", step_done, 0);
        chk("spike_clear", spike, 0);
        chk("ready_again", step_ready, 1);
        chk("done_pulses", dones, d0 + 1);
        chk("accept_count", accepts, a0 + 1);
        clr_count = 1'b0;
    endtask

    initial begin
        int d0, a0, thr, esm;
        // reset with no clock edge
        #1 reset = 1'b1;
        #1;
        chk("rst_v_mem", $signed(v_mem), 0);
        chk("rst_spike", spike, 0);
        chk("rst_done", step_done, 0);
        chk("rst_refr", refractory, 0);
        chk("rst_count", spike_count, 0);
        chk("rst_ready", step_ready, 1);
        @(negedge clk);
        reset = 1'b0;

        // integrate
        do_step(16'h1000, 16'h2000, 0, 0, 32'h10000, 0, 0);
        chk("integ_v1", $signed(v_mem), 32'h1000);
        do_step(16'h1000, 16'h2000, 0, 0, 32'h10000, 0, 0);
        chk("integ_v2", $signed(v_mem), 32'h1E00);

        // fire and refractory
        do_reset();
        for (int i = 0; i < 6; i++) begin
            do_step(0, 16'h1000, 0, 0, 32'h1000, 0, 0);
        end
        chk("fire_count2", spike_count, 2);

        // floor clamp
        do_reset();
        do_step(0, 0, 16'hFFFF, 0, 32'h10000, 0, 0);
        chk("floor_v1", $signed(v_mem), -65535);
        do_step(0, 0, 16'hFFFF, 0, 32'h10000, 0, 0);
        chk("floor_v2", $signed(v_mem), -65536);

        // handshake: step_valid held 20 cycles
        do_reset();
        @(negedge clk);
        ES_plus_reg = 0; ES_minus_reg = 16'h0100; IS_plus_reg = 0; IS_minus_reg = 0;
        threshold = 24'h7FFFFF;
        d0 = dones; a0 = accepts;
        step_valid = 1'b1;
        repeat (20) @(negedge clk);
        step_valid = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 5; i++) model_step(0, 16'h0100, 0, 0, 32'h7FFFFF, 0);
        chk("hs_accepts", accepts, a0 + 5);
        chk("hs_dones", dones, d0 + 5);
        chk("hs_v_mem", $signed(v_mem), m_v);

        // glitch on step_valid during SUM
        do_step(0, 16'h0100, 0, 0, 32'h7FFFFF, 1, 0);

        // reset during UPDATE aborts the step
        do_reset();
        @(negedge clk);
        ES_plus_reg = 0; ES_minus_reg = 16'h1000; IS_plus_reg = 0; IS_minus_reg = 0;
        threshold = 24'h001000;
        d0 = dones;
        step_valid = 1'b1;
        @(posedge clk); #1;
        step_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("abort_v_mem", $signed(v_mem), 0);
        chk("abort_ready", step_ready, 1);
        @(posedge clk); #1;
        chk("abort_spike", spike, 0);
        chk("abort_done", step_done, 0);
        @(negedge clk);
        reset = 1'b0;
        m_v = 0; m_ref = 0; m_cnt = 0;
        repeat (3) @(negedge clk);
        chk("abort_no_done", dones, d0);

        // clr_count coincident with a spike
        do_step(0, 16'h1000, 0, 0, 32'h1000, 0, 0);
        chk("pre_clr_count", spike_count, 1);
        for (int i = 0; i < 4; i++) do_step(0, 16'h1000, 0, 0, 32'h1000, 0, 0);
        do_step(0, 16'h1000, 0, 0, 32'h1000, 0, 1);
        chk("clr_count_zero", spike_count, 0);

        // randomized steps
        do_reset();
        for (int i = 0; i < 60; i++) begin
            esm = int'($urandom_range(0, 65535));
            thr = ($urandom_range(0, 3) == 0) ? 32'h7FFFFF : int'($urandom_range(2048, 262144));
            do_step(int'($urandom_range(0, 65535)), esm, int'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 65535)), thr, 1'($urandom),
                    ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
